// File: rtl/video_types.sv
// Shared video timing types and default LCD geometry used by the graphics peripheral.
package video_types;

    typedef enum logic [1:0] {
        HBLANK = 2'd0,
        VBLANK = 2'd1,
        OAM    = 2'd2,
        XFER   = 2'd3
    } LcdMode;

    localparam int LCD_LINES     = 144;
    localparam int DOTS_PER_LINE = 456;
    localparam int OAM_DOTS      = 80;
    localparam int XFER_DOTS     = 172;
    localparam int TOTAL_LINES   = 154;

endpackage

// File: rtl/lcd_stat_irq.sv
// STAT interrupt line: ORs the enabled sources and fires only on the line's rising edge,
// so a source that turns on while the line is already high does not re-trigger.
module lcd_stat_irq
    import video_types::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  LcdMode     mode,
    input  logic       coincidence,
    input  logic [3:0] stat_int_en,
    output logic       stat_irq
);

    logic stat_line;
    logic line_q;

    always_comb begin
        stat_line = enable & ((stat_int_en[0] & (mode == HBLANK)) |
                              (stat_int_en[1] & (mode == VBLANK)) |
                              (stat_int_en[2] & (mode == OAM))    |
                              (stat_int_en[3] & coincidence));
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            line_q <= 1'b0;
        end else begin
            line_q <= stat_line;
        end
    end

    assign stat_irq = stat_line & ~line_q;

endmodule

// File: rtl/lcd_timing_gen.sv
// Dot/line sequencer for the scanline renderer: LY counter, STAT mode, LYC compare,
// per-line drawline and per-frame render_reset pulses, VBlank and STAT interrupt requests.
module lcd_timing_gen
    import video_types::*;
#(
    parameter int CLK_PER_DOT   = 1,
    parameter int DOTS_PER_LINE = video_types::DOTS_PER_LINE,
    parameter int OAM_DOTS      = video_types::OAM_DOTS,
    parameter int XFER_DOTS     = video_types::XFER_DOTS,
    parameter int VISIBLE_LINES = LCD_LINES,
    parameter int TOTAL_LINES   = video_types::TOTAL_LINES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_int_en,
    output logic       drawline,
    output logic       render_reset,
    output logic [7:0] ly,
    output logic [1:0] mode,
    output logic       coincidence,
    output logic       vblank_irq,
    output logic       stat_irq
);

    localparam int              PS_W         = (CLK_PER_DOT > 1) ? $clog2(CLK_PER_DOT) : 1;
    localparam logic [PS_W-1:0] PS_LAST      = PS_W'(CLK_PER_DOT - 1);
    localparam logic [8:0]      LAST_DOT     = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0]      XFER_START   = 9'(OAM_DOTS);
    localparam logic [8:0]      HBLANK_START = 9'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0]      LAST_LY      = 8'(TOTAL_LINES - 1);
    localparam logic [7:0]      VBLANK_LY    = 8'(VISIBLE_LINES);

    logic            active;
    logic [PS_W-1:0] prescale;
    logic [PS_W-1:0] prescale_next;
    logic [8:0]      dot;
    logic [8:0]      dot_next;
    logic [7:0]      ly_next;
    logic            ps_wrap;
    LcdMode          mode_q;
    LcdMode          mode_next;

    // Next counter values; the mode is derived from where the counters land so that
    // mode, ly and coincidence all change on the same clock as the dot they describe.
    always_comb begin
        ps_wrap       = (prescale == PS_LAST);
        prescale_next = ps_wrap ? '0 : prescale + 1'b1;
        dot_next      = dot;
        ly_next       = ly;
        if (ps_wrap) begin
            if (dot == LAST_DOT) begin
                dot_next = '0;
                ly_next  = (ly == LAST_LY) ? 8'd0 : ly + 8'd1;
            end else begin
                dot_next = dot + 9'd1;
            end
        end
        if (ly_next >= VBLANK_LY) begin
            mode_next = VBLANK;
        end else if (dot_next < XFER_START) begin
            mode_next = OAM;
        end else if (dot_next < HBLANK_START) begin
            mode_next = XFER;
        end else begin
            mode_next = HBLANK;
        end
    end

    // The first enabled clock after idle is line 0 dot 0 in OAM scan with render_reset.
    always_ff @(posedge clk) begin
        if (reset || !lcd_enable) begin
            active       <= 1'b0;
            prescale     <= '0;
            dot          <= '0;
            ly           <= 8'd0;
            mode_q       <= HBLANK;
            drawline     <= 1'b0;
            render_reset <= 1'b0;
            vblank_irq   <= 1'b0;
            coincidence  <= (lyc == 8'd0);
        end else if (!active) begin
            active       <= 1'b1;
            prescale     <= '0;
            dot          <= '0;
            ly           <= 8'd0;
            mode_q       <= OAM;
            drawline     <= 1'b0;
            render_reset <= 1'b1;
            vblank_irq   <= 1'b0;
            coincidence  <= (lyc == 8'd0);
        end else begin
            prescale     <= prescale_next;
            dot          <= dot_next;
            ly           <= ly_next;
            mode_q       <= mode_next;
            coincidence  <= (ly_next == lyc);
            drawline     <= ps_wrap && (dot_next == XFER_START) && (ly_next < VBLANK_LY);
            render_reset <= ps_wrap && (dot_next == 9'd0) && (ly_next == 8'd0);
            vblank_irq   <= ps_wrap && (dot_next == 9'd0) && (ly_next == VBLANK_LY);
        end
    end

    assign mode = mode_q;

    lcd_stat_irq u_stat_irq (
        .clk         (clk),
        .reset       (reset),
        .enable      (active),
        .mode        (mode_q),
        .coincidence (coincidence),
        .stat_int_en (stat_int_en),
        .stat_irq    (stat_irq)
    );

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: one instance at 1 clk/dot, one at 4 clk/dot, shared inputs.
module tb_lcd_timing_gen;

    localparam int FRAME = 70224;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_enable;
    logic [7:0] lyc;
    logic [3:0] stat_int_en;

    logic       drawline, render_reset, coincidence, vblank_irq, stat_irq;
    logic [7:0] ly;
    logic [1:0] mode;

    logic       drawline_x4, render_reset_x4, coincidence_x4, vblank_irq_x4, stat_irq_x4;
    logic [7:0] ly_x4;
    logic [1:0] mode_x4;

    int tests = 0;
    int fails = 0;
    int cyc   = -1;

    int dl_count = 0, dl_first = -1, dl_prev = -1, dl_bad_gap = 0;
    int vb_count = 0, mode1_clks = 0, stat_count = 0, pulse_count = 0;
    int dl4_count = 0;
    int dl4_time[2];
    int snap;

    always #5 clk = ~clk;

    lcd_timing_gen #(.CLK_PER_DOT(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .lcd_enable   (lcd_enable),
        .lyc          (lyc),
        .stat_int_en  (stat_int_en),
        .drawline     (drawline),
        .render_reset (render_reset),
        .ly           (ly),
        .mode         (mode),
        .coincidence  (coincidence),
        .vblank_irq   (vblank_irq),
        .stat_irq     (stat_irq)
    );

    lcd_timing_gen #(.CLK_PER_DOT(4)) dut_x4 (
        .clk          (clk),
        .reset        (reset),
        .lcd_enable   (lcd_enable),
        .lyc          (lyc),
        .stat_int_en  (stat_int_en),
        .drawline     (drawline_x4),
        .render_reset (render_reset_x4),
        .ly           (ly_x4),
        .mode         (mode_x4),
        .coincidence  (coincidence_x4),
        .vblank_irq   (vblank_irq_x4),
        .stat_irq     (stat_irq_x4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [7:0] l, input logic [3:0] s);
        reset       = r;
        lcd_enable  = e;
        lyc         = l;
        stat_int_en = s;
    endtask

    // One clock: sample on the falling edge and accumulate event statistics.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (cyc < FRAME) begin
            if (drawline === 1'b1) begin
                if (dl_count == 0) dl_first = cyc;
                else if (cyc - dl_prev != 456) dl_bad_gap++;
                dl_prev = cyc;
                dl_count++;
            end
            if (vblank_irq === 1'b1) vb_count++;
            if (mode === 2'd1) mode1_clks++;
        end
        if (stat_irq === 1'b1) stat_count++;
        if (drawline === 1'b1)     pulse_count++;
        if (render_reset === 1'b1) pulse_count++;
        if (vblank_irq === 1'b1)   pulse_count++;
        if (stat_irq === 1'b1)     pulse_count++;
        if (drawline_x4 === 1'b1 || render_reset_x4 === 1'b1 ||
            vblank_irq_x4 === 1'b1 || stat_irq_x4 === 1'b1) pulse_count++;
        if (drawline_x4 === 1'b1 && dl4_count < 2) begin
            dl4_time[dl4_count] = cyc;
            dl4_count++;
        end
    endtask

    task automatic runTo(input int t);
        while (cyc < t) step();
    endtask

    initial begin
        dl4_time[0] = -1;
        dl4_time[1] = -1;

        applyStimulus(1'b1, 1'b1, 8'd10, 4'b1000);
        repeat (3) @(negedge clk);
        checkOutput("reset_ly", 32'(ly), 0);
        checkOutput("reset_mode", 32'(mode), 0);
        checkOutput("reset_drawline", 32'(drawline), 0);
        checkOutput("reset_render_reset", 32'(render_reset), 0);
        checkOutput("reset_coincidence", 32'(coincidence), 0);
        checkOutput("reset_stat_irq", 32'(stat_irq), 0);
        checkOutput("reset_vblank_irq", 32'(vblank_irq), 0);

        applyStimulus(1'b0, 1'b1, 8'd10, 4'b1000);
        step();
        checkOutput("start_render_reset", 32'(render_reset), 1);
        checkOutput("start_mode", 32'(mode), 2);
        checkOutput("start_ly", 32'(ly), 0);
        checkOutput("start_stat_irq", 32'(stat_irq), 0);
        checkOutput("start_render_reset_x4", 32'(render_reset_x4), 1);
        checkOutput("start_mode_x4", 32'(mode_x4), 2);
        step();
        checkOutput("render_reset_one_clk", 32'(render_reset), 0);

        runTo(79);   checkOutput("mode_dot79", 32'(mode), 2);
        runTo(80);   checkOutput("mode_dot80", 32'(mode), 3);
                     checkOutput("drawline_dot80", 32'(drawline), 1);
        runTo(251);  checkOutput("mode_dot251", 32'(mode), 3);
        runTo(252);  checkOutput("mode_dot252", 32'(mode), 0);
        runTo(319);  checkOutput("mode_x4_dot79", 32'(mode_x4), 2);
        runTo(455);  checkOutput("mode_dot455", 32'(mode), 0);
                     checkOutput("ly_dot455", 32'(ly), 0);
        runTo(456);  checkOutput("mode_line1", 32'(mode), 2);
                     checkOutput("ly_line1", 32'(ly), 1);

        runTo(4559); checkOutput("coinc_before_lyc", 32'(coincidence), 0);
                     checkOutput("stat_before_lyc", 32'(stat_irq), 0);
        runTo(4560); checkOutput("ly_line10", 32'(ly), 10);
                     checkOutput("coinc_line10", 32'(coincidence), 1);
                     checkOutput("stat_line10", 32'(stat_irq), 1);
        runTo(4561); checkOutput("stat_single_pulse", 32'(stat_irq), 0);
        runTo(5015); checkOutput("coinc_line10_end", 32'(coincidence), 1);
        runTo(5016); checkOutput("coinc_line11", 32'(coincidence), 0);
        runTo(5100); checkOutput("stat_count_lyc10", 32'(stat_count), 1);

        applyStimulus(1'b0, 1'b1, 8'd11, 4'b1000);
        step();
        checkOutput("coinc_lyc_write", 32'(coincidence), 1);
        checkOutput("stat_lyc_write", 32'(stat_irq), 1);

        runTo(5482);
        applyStimulus(1'b0, 1'b1, 8'd20, 4'b1001);
        runTo(8916); checkOutput("stat_mode0_line19", 32'(stat_irq), 1);
        snap = stat_count;
        runTo(9827); checkOutput("stat_blocked_line20", 32'(stat_count - snap), 0);
        runTo(9828); checkOutput("stat_mode0_line21", 32'(stat_irq), 1);
        applyStimulus(1'b0, 1'b1, 8'd20, 4'b0000);

        runTo(65663); checkOutput("ly_last_visible", 32'(ly), 143);
                      checkOutput("mode_last_visible", 32'(mode), 0);
                      checkOutput("vblank_early", 32'(vblank_irq), 0);
        runTo(65664); checkOutput("ly_vblank", 32'(ly), 144);
                      checkOutput("mode_vblank", 32'(mode), 1);
                      checkOutput("vblank_irq", 32'(vblank_irq), 1);
        runTo(FRAME - 1); checkOutput("ly_last", 32'(ly), 153);
                          checkOutput("mode_last", 32'(mode), 1);
        runTo(FRAME); checkOutput("wrap_render_reset", 32'(render_reset), 1);
                      checkOutput("wrap_ly", 32'(ly), 0);
                      checkOutput("wrap_mode", 32'(mode), 2);

        checkOutput("drawline_count", 32'(dl_count), 144);
        checkOutput("drawline_first", 32'(dl_first), 80);
        checkOutput("drawline_bad_gap", 32'(dl_bad_gap), 0);
        checkOutput("vblank_count", 32'(vb_count), 1);
        checkOutput("mode1_clks", 32'(mode1_clks), 4560);
        checkOutput("drawline_x4_first", 32'(dl4_time[0]), 320);
        checkOutput("drawline_x4_second", 32'(dl4_time[1]), 2144);

        runTo(FRAME + 5 * 456 + 200);
        checkOutput("pre_disable_ly", 32'(ly), 5);
        checkOutput("pre_disable_mode", 32'(mode), 3);
        applyStimulus(1'b0, 1'b0, 8'd0, 4'b0001);
        step();
        checkOutput("disable_ly", 32'(ly), 0);
        checkOutput("disable_mode", 32'(mode), 0);
        checkOutput("disable_drawline", 32'(drawline), 0);
        checkOutput("disable_coinc_lyc0", 32'(coincidence), 1);
        snap = pulse_count;
        repeat (20) step();
        checkOutput("disable_no_pulses", 32'(pulse_count - snap), 0);

        applyStimulus(1'b0, 1'b1, 8'd0, 4'b0000);
        step();
        checkOutput("reenable_render_reset", 32'(render_reset), 1);
        checkOutput("reenable_mode", 32'(mode), 2);
        checkOutput("reenable_ly", 32'(ly), 0);
        checkOutput("reenable_render_reset_x4", 32'(render_reset_x4), 1);
        snap = cyc;
        runTo(snap + 80);
        checkOutput("reenable_drawline", 32'(drawline), 1);
        checkOutput("reenable_mode3", 32'(mode), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
